delay_timer_arbiter: RTL and testbench
======================================

Name: delay_timer_arbiter

Overview:
Shares one prescaled down-counting delay timer among 4 requesters. The timebase is derived from clk in the same way as the project clock divider. Each requester asks for a delay of N ticks. A round-robin arbiter grants the timer to one requester at a time, loads the delay, counts it out, then pulses that requester's done line. The block sits between the board-level sequencing logic (LED/display state machines) and the single shared timebase.

Parameters:
PRESCALE, 50000000, clk cycles per timer tick (default gives 1 s ticks at 50 MHz); must be >= 1
CNT_W, 16, width of each requested delay and of the internal tick counter
PRE_W, 26, width of the prescaler counter; must hold PRESCALE-1

Ports:
clk  input  1  system clock; all state updates on posedge
ar  input  1  asynchronous active-low reset; clears all state immediately
req  input  4  level request per requester; held high until done or cancel
dly  input  4*CNT_W  requested delay; requester i uses bits [i*CNT_W +: CNT_W]
grant  output  4  one-hot owner of the timer; 0 when idle
done  output  4  one-cycle completion pulse to the granted requester
busy  output  1  high whenever state != IDLE
tick  output  1  one-cycle pulse at every prescaler rollover while counting

Behaviour:
- Reset (ar low, async): state=IDLE, grant=0, done=0, busy=0, tick=0, prescaler=0, counter=0, rr pointer=0.
- States: IDLE, COUNT, DONE. All outputs are registered.
- IDLE: if any req bit is high at a clk edge, select the winner by round-robin: search from ptr, ptr+1, ... mod 4, and take the first high bit.
  - At that same edge: state->COUNT, grant=onehot(winner), counter=dly[winner], prescaler=0.
  - dly is sampled only at this edge. Later changes to dly are ignored.
- COUNT:
  - If req[g] is low (cancel): next edge -> IDLE, grant=0, no done pulse, ptr=g+1 mod 4.
  - Else if counter==0: next edge -> DONE, done[g]=1.
  - Else, when prescaler==PRESCALE-1: prescaler<=0, counter<=counter-1, and tick is asserted for 1 cycle.
  - Otherwise: prescaler<=prescaler+1.
  - Cancel takes priority over counter==0 and over tick in the same cycle.
- DONE: lasts exactly 1 cycle, with done[g]=1 and grant still = onehot(g). Next edge: state=IDLE, grant=0, done=0, ptr=g+1 mod 4.
- Latency: the grant edge is E0 (req sampled high in IDLE).
  - counter reaches 0 at edge E0+N*PRESCALE.
  - done is high for the cycle following edge E0+N*PRESCALE+1.
  - N=0 gives done after edge E0+1.
- tick is 0 outside COUNT. With PRESCALE=1, tick fires every COUNT cycle while counter!=0.
- Turnaround: at least 1 IDLE cycle between consecutive grants.
- A requester still holding req in IDLE after its own done is re-granted only if no higher-rotation requester is pending.
- req changes during DONE have no effect on the current transaction.
- Reset mid-operation aborts immediately. No done pulse is issued for the aborted request.
- Counter does not wrap: the decrement only happens when counter!=0.
- Prescaler arithmetic is unsigned, width PRE_W. Counter arithmetic is unsigned, width CNT_W.

Test Plan:
- Single request: PRESCALE=4, req=0001, dly0=3 → grant=0001 at E0; tick pulses at E0+4, E0+8, E0+12; done[0] high 1 cycle after edge E0+13; grant=0 and busy=0 after E0+14.
- Zero delay: PRESCALE=4, req=0100, dly2=0 → grant=0100 at E0; done[2] after edge E0+1; no tick pulses.
- Simultaneous requests: after reset, req=0101, dly0=dly2=1, PRESCALE=2 → requester 0 is served first; requester 2 is granted only after 1 IDLE cycle; done[2] follows; ptr=3 at the end.
- Fairness: req=1111 held high, each requester dropping its bit the cycle after its done and re-raising 2 cycles later → grant sequence 0001, 0010, 0100, 1000, 0001; no requester is skipped.
- Cancel: PRESCALE=4, dly1=5, req1 dropped 6 cycles after grant → IDLE on next edge; done stays 0; a pending req3 is granted next.
- Reset mid-count: ar pulled low during COUNT → grant, busy, done, tick all go to 0 immediately without a clock edge; after ar releases, a new req0 is granted with ptr=0.

Source files
------------

// File: rtl/delay_timer_arbiter.sv
// -----------------------------------------------------------------------------
// delay_timer_arbiter
//
// Shares one prescaled down-counting delay timer among four requesters.
// A round-robin arbiter picks one pending requester, loads its requested
// delay, counts it out in prescaled ticks and then pulses that requester's
// done line for one cycle. Dropping req while owning the timer cancels the
// delay without a done pulse.
//
// Parameters:
//   PRESCALE  clk cycles per timer tick (>= 1)
//   CNT_W     width of each requested delay and of the tick counter
//   PRE_W     width of the prescaler counter (must hold PRESCALE-1)
//
// Ports:
//   clk    system clock, all state updates on posedge
//   ar     asynchronous active-low reset
//   req    level request per requester, held until done or cancel
//   dly    requested delays, requester i uses dly[i*CNT_W +: CNT_W]
//   grant  one-hot owner of the timer, 0 when idle
//   done   one-cycle completion pulse to the owner
//   busy   high whenever the timer is not idle
//   tick   one-cycle pulse on every prescaler rollover while counting
// -----------------------------------------------------------------------------
module delay_timer_arbiter #(
    parameter int PRESCALE = 50000000,
    parameter int CNT_W    = 16,
    parameter int PRE_W    = 26
) (
    input  logic               clk,
    input  logic               ar,
    input  logic [3:0]         req,
    input  logic [4*CNT_W-1:0] dly,
    output logic [3:0]         grant,
    output logic [3:0]         done,
    output logic               busy,
    output logic               tick
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    state_t             state;
    logic [1:0]         ptr;        // first requester to consider next time
    logic [1:0]         owner;      // index of the current grant holder
    logic [PRE_W-1:0]   prescaler;
    logic [CNT_W-1:0]   counter;

    logic [1:0]         win_idx;
    logic               win_found;

    // Round-robin search starting at ptr; the 2-bit sum wraps modulo 4.
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        win_idx   = 2'd0;
        win_found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!win_found && req[ptr + 2'(i)]) begin
                win_idx   = ptr + 2'(i);
                win_found = 1'b1;
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge ar) begin
        if (!ar) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            owner     <= 2'd0;
            prescaler <= '0;
            counter   <= '0;
            grant     <= 4'b0000;
            done      <= 4'b0000;
            busy      <= 1'b0;
            tick      <= 1'b0;
        end else begin
            tick <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state     <= COUNT;
                        owner     <= win_idx;
                        grant     <= 4'b0001 << win_idx;
                        // The delay is captured only here; later dly changes
                        // do not affect the running transaction.
                        counter   <= dly[win_idx*CNT_W +: CNT_W];
                        prescaler <= '0;
                        busy      <= 1'b1;
                    end
                end

                COUNT: begin
                    // Cancel wins over completion and over a pending tick.
                    if (!req[owner]) begin
                        state <= IDLE;
                        grant <= 4'b0000;
                        busy  <= 1'b0;
                        ptr   <= owner + 2'd1;
                    end else if (counter == '0) begin
                        state <= DONE;
                        done  <= grant;
                    end else if (prescaler == PRE_LAST) begin
                        prescaler <= '0;
                        counter   <= counter - CNT_W'(1);
                        tick      <= 1'b1;
                    end else begin
                        prescaler <= prescaler + PRE_W'(1);
                    end
                end

                DONE: begin
                    // req is ignored here; the transaction is already complete.
                    state <= IDLE;
                    grant <= 4'b0000;
                    done  <= 4'b0000;
                    busy  <= 1'b0;
                    ptr   <= owner + 2'd1;
                end

                default: begin
                    state <= IDLE;
                    grant <= 4'b0000;
                    done  <= 4'b0000;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_delay_timer_arbiter.sv
// -----------------------------------------------------------------------------
// tb_delay_timer_arbiter
//
// Directed scenarios followed by randomized requests, cancels, delay changes
// and mid-operation resets. Expected outputs come from a transaction-level
// model that tracks the grant edge of the current owner and derives tick,
// done and release timing from the elapsed cycle count.
// -----------------------------------------------------------------------------
module tb_delay_timer_arbiter;

    localparam int P  = 4;
    localparam int CW = 16;

    logic            clk;
    logic            ar;
    logic [3:0]      req;
    logic [4*CW-1:0] dly;
    logic [3:0]      grant;
    logic [3:0]      done;
    logic            busy;
    logic            tick;

    delay_timer_arbiter #(
        .PRESCALE (P),
        .CNT_W    (CW),
        .PRE_W    (26)
    ) dut (
        .clk   (clk),
        .ar    (ar),
        .req   (req),
        .dly   (dly),
        .grant (grant),
        .done  (done),
        .busy  (busy),
        .tick  (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model state
    bit         m_active;
    int         m_ptr;
    int         m_owner;
    int         m_e0;
    int         m_n;
    logic [3:0] e_grant;
    logic [3:0] e_done;
    logic       e_busy;
    logic       e_tick;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_ptr    = 0;
        m_owner  = 0;
        m_e0     = 0;
        m_n      = 0;
        e_grant  = 4'b0000;
        e_done   = 4'b0000;
        e_busy   = 1'b0;
        e_tick   = 1'b0;
    endtask

    // One clock edge of the reference, using the inputs present at that edge.
    // A transaction granted at edge e0 with delay N occupies elapsed edges
    // 1..N*P as counting (tick where elapsed is a multiple of P), N*P+1 as the
    // done edge and N*P+2 as the release edge.
    task automatic model_step();
        int el;
        int total;
        int w;
        e_tick = 1'b0;
        e_done = 4'b0000;
        if (!m_active) begin
            w = -1;
            for (int i = 0; i < 4; i++) begin
                int k;
                k = (m_ptr + i) % 4;
                if (w < 0 && req[k]) w = k;
            end
            if (w >= 0) begin
                m_active = 1'b1;
                m_owner  = w;
                m_e0     = cyc;
                m_n      = int'(dly[w*CW +: CW]);
                e_grant  = 4'b0001 << w;
                e_busy   = 1'b1;
            end
        end else begin
            el    = cyc - m_e0;
            total = m_n * P;
            if (el == total + 2 || !req[m_owner]) begin
                m_active = 1'b0;
                m_ptr    = (m_owner + 1) % 4;
                e_grant  = 4'b0000;
                e_busy   = 1'b0;
            end else if (el == total + 1) begin
                e_done = 4'b0001 << m_owner;
            end else if (el % P == 0) begin
                e_tick = 1'b1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        check("grant", 32'(grant), 32'(e_grant));
        check("done",  32'(done),  32'(e_done));
        check("busy",  32'(busy),  32'(e_busy));
        check("tick",  32'(tick),  32'(e_tick));
    endtask

    // Asserts reset between edges and checks the outputs clear without a clock.
    task automatic apply_reset();
        req = 4'b0000;
        ar  = 1'b0;
        #1;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_done",  32'(done),  32'h0);
        check("rst_busy",  32'(busy),  32'h0);
        check("rst_tick",  32'(tick),  32'h0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        ar = 1'b1;
    endtask

    // Runs until done shows up, returning the edges since the grant and ticks seen.
    task automatic run_to_done(output int edges, output int ticks);
        bit seen;
        edges = 0;
        ticks = 0;
        seen  = 1'b0;
        while (!seen && edges < 60) begin
            step();
            edges++;
            if (tick) ticks++;
            if (done != 4'b0000) seen = 1'b1;
        end
        if (!seen) check("done_timeout", 32'(edges), 32'h0);
    endtask

    initial begin
        int edges;
        int ticks;
        int hold [4];
        logic [3:0] seq [$];
        logic [3:0] prev_grant;
        logic [3:0] fair_exp [5];

        ar  = 1'b1;
        req = 4'b0000;
        dly = '0;
        model_reset();
        #2;
        apply_reset();

        // Single request, delay 3: ticks at E0+4/8/12, done after E0+13.
        dly[0*CW +: CW] = 16'd3;
        req = 4'b0001;
        step();
        check("single_grant", 32'(grant), 32'h1);
        dly[0*CW +: CW] = 16'd9;    // must not disturb the running delay
        run_to_done(edges, ticks);
        check("single_done_edge", 32'(edges), 32'd13);
        check("single_ticks", 32'(ticks), 32'd3);
        req = 4'b0000;
        step();
        step();
        check("single_idle_busy", 32'(busy), 32'h0);

        // Zero delay: done right after E0+1, no ticks.
        apply_reset();
        dly[2*CW +: CW] = 16'd0;
        req = 4'b0100;
        step();
        check("zero_grant", 32'(grant), 32'h4);
        run_to_done(edges, ticks);
        check("zero_done_edge", 32'(edges), 32'd1);
        check("zero_ticks", 32'(ticks), 32'd0);
        req = 4'b0000;
        step();

        // Simultaneous requests 0 and 2: 0 first, then 2, pointer ends at 3.
        apply_reset();
        dly[0*CW +: CW] = 16'd1;
        dly[2*CW +: CW] = 16'd1;
        req = 4'b0101;
        prev_grant = 4'b0000;
        seq.delete();
        for (int i = 0; i < 30; i++) begin
            step();
            if (grant != 4'b0000 && prev_grant == 4'b0000) seq.push_back(grant);
            prev_grant = grant;
            req = req & ~done;
        end
        check("simul_count", 32'(seq.size()), 32'd2);
        if (seq.size() >= 2) begin
            check("simul_first", 32'(seq[0]), 32'h1);
            check("simul_second", 32'(seq[1]), 32'h4);
        end
        dly[3*CW +: CW] = 16'd0;
        req = 4'b1001;
        step();
        check("simul_ptr3", 32'(grant), 32'h8);
        req = 4'b0000;
        step();
        step();

        // Fairness with every requester re-raising shortly after its done.
        apply_reset();
        dly = '0;
        req = 4'b1111;
        for (int i = 0; i < 4; i++) hold[i] = 0;
        prev_grant = 4'b0000;
        seq.delete();
        for (int c = 0; c < 40; c++) begin
            step();
            if (grant != 4'b0000 && prev_grant == 4'b0000) seq.push_back(grant);
            prev_grant = grant;
            for (int i = 0; i < 4; i++) begin
                if (hold[i] > 0) begin
                    hold[i]--;
                    if (hold[i] == 0) req[i] = 1'b1;
                end
                if (e_done[i]) begin
                    req[i]  = 1'b0;
                    hold[i] = 2;
                end
            end
        end
        fair_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        if (seq.size() < 5) check("fair_count", 32'(seq.size()), 32'd5);
        else for (int i = 0; i < 5; i++) check($sformatf("fair_%0d", i), 32'(seq[i]), 32'(fair_exp[i]));

        // Cancel requester 1 mid-count; pending requester 3 is served next.
        apply_reset();
        dly[1*CW +: CW] = 16'd5;
        dly[3*CW +: CW] = 16'd1;
        req = 4'b1010;
        step();
        check("cancel_grant", 32'(grant), 32'h2);
        repeat (6) step();
        req[1] = 1'b0;
        step();
        check("cancel_idle", 32'(grant), 32'h0);
        check("cancel_no_done", 32'(done), 32'h0);
        step();
        check("cancel_next", 32'(grant), 32'h8);
        req = 4'b0000;
        step();
        step();

        // Reset mid-count restores the pointer to 0.
        apply_reset();
        dly[1*CW +: CW] = 16'd0;
        req = 4'b0010;
        run_to_done(edges, ticks);
        req = 4'b0000;
        step();
        step();
        dly[2*CW +: CW] = 16'd5;
        req = 4'b0100;
        step();
        check("midrst_grant", 32'(grant), 32'h4);
        repeat (5) step();
        apply_reset();
        req = 4'b0110;
        step();
        check("midrst_ptr0", 32'(grant), 32'h2);
        req = 4'b0000;
        step();
        step();

        // Randomized traffic: requests, cancels, dly churn and rare resets.
        for (int c = 0; c < 3000; c++) begin
            step();
            for (int i = 0; i < 4; i++) begin
                if (e_done[i]) begin
                    if ($urandom_range(3) != 0) req[i] = 1'b0;
                end else if (m_active && m_owner == i && req[i]) begin
                    if ($urandom_range(39) == 0) req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(5) == 0) begin
                    req[i] = 1'b1;
                    dly[i*CW +: CW] = CW'($urandom_range(4));
                end
                if ($urandom_range(7) == 0) dly[i*CW +: CW] = CW'($urandom_range(4));
            end
            if ($urandom_range(499) == 0) apply_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
